// File: rtl/block_map_ctrl.sv
// Soft-block tile map for the arena. It generates a pseudo-random map after reset or regen,
// then serves render and collision lookups and accepts tile clears.
module block_map_ctrl #(
    parameter int          COLS = 33,
    parameter int          ROWS = 27,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       regen,
    input  logic [9:0] block_w_addr,
    input  logic       block_we,
    input  logic [9:0] x_a,
    input  logic [9:0] y_a,
    input  logic [9:0] col_addr,
    output logic       block_on,
    output logic       col_hit,
    output logic       init_done,
    output logic       block_cleared,
    output logic [9:0] cleared_count
);
    // state | meaning
    // INIT  | writing one generated tile per cycle, lookups return 0
    // RUN   | map live, clears and lookups enabled
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int         TILES      = COLS * ROWS;
    localparam logic [9:0] L_LAST     = 10'(TILES - 1);
    localparam logic [9:0] L_COL_LAST = 10'(COLS - 1);
    localparam logic [9:0] L_ROW_LAST = 10'(ROWS - 1);
    localparam logic [9:0] L_COLS     = 10'(COLS);

    logic [0:0]  r_state;
    logic [9:0]  r_addr;
    logic [9:0]  r_col;
    logic [9:0]  r_row;
    logic [15:0] r_lfsr;
    logic        r_init_done;
    logic        r_block_on;
    logic        r_col_hit;
    logic        r_cleared;
    logic [9:0]  r_count;
    logic        r_map [0:TILES-1];

    logic       w_lfsr_fb;
    logic       w_gen_bit;
    logic       w_init_wr;
    logic       w_clr_wr;
    logic       w_clr_hit;
    logic [9:0] w_wr_addr;
    logic [9:0] w_pix_col;
    logic [9:0] w_pix_row;
    logic [9:0] w_pix_addr;
    logic       w_pix_ok;
    logic [9:0] w_rd_pix;
    logic       w_col_ok;
    logic [9:0] w_rd_col;

    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Pillars (odd col and odd row) and the player spawn corner are always left empty.
    assign w_gen_bit = (r_lfsr[1:0] != 2'b00) && !(r_col[0] && r_row[0]) &&
                       (r_addr != 10'd0) && (r_addr != 10'd1) && (r_addr != L_COLS);

    assign w_init_wr = (r_state == S_INIT) && !regen;
    assign w_clr_wr  = (r_state == S_RUN) && !regen && block_we && (block_w_addr <= L_LAST);
    assign w_wr_addr = (block_w_addr <= L_LAST) ? block_w_addr : '0;
    assign w_clr_hit = w_clr_wr && r_map[w_wr_addr];

    assign w_pix_col  = {4'b0000, x_a[9:4]};
    assign w_pix_row  = {4'b0000, y_a[9:4]};
    assign w_pix_ok   = (w_pix_col <= L_COL_LAST) && (w_pix_row <= L_ROW_LAST);
    assign w_pix_addr = w_pix_col + w_pix_row * L_COLS;
    assign w_rd_pix   = w_pix_ok ? w_pix_addr : '0;
    assign w_col_ok   = (col_addr <= L_LAST);
    assign w_rd_col   = w_col_ok ? col_addr : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_addr      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_lfsr      <= SEED;
            r_init_done <= 1'b0;
        end else if (regen) begin
            r_state     <= S_INIT;
            r_addr      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
            if (r_addr == L_LAST) begin
                r_state     <= S_RUN;
                r_init_done <= 1'b1;
            end else begin
                r_addr <= r_addr + 10'd1;
                if (r_col == L_COL_LAST) begin
                    r_col <= '0;
                    r_row <= r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

    // Map storage has no reset; INIT rewrites every tile before lookups are enabled.
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_map[r_addr] <= w_gen_bit;
        end else if (w_clr_wr) begin
            r_map[w_wr_addr] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block_on <= 1'b0;
            r_col_hit  <= 1'b0;
            r_cleared  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_block_on <= w_pix_ok && r_init_done && r_map[w_rd_pix];
            r_col_hit  <= w_col_ok && r_init_done && r_map[w_rd_col];
            r_cleared  <= w_clr_hit;
            if (regen) begin
                r_count <= '0;
            end else if (w_clr_hit) begin
                r_count <= r_count + 10'd1;
            end
        end
    end

    assign block_on      = r_block_on;
    assign col_hit       = r_col_hit;
    assign init_done     = r_init_done;
    assign block_cleared = r_cleared;
    assign cleared_count = r_count;
endmodule

// File: tb/tb_block_map_ctrl.sv
// Self-checking bench for block_map_ctrl: a reference map model feeds a scoreboard of
// expected col_hit/block_on values that are compared when the registered outputs appear.
module tb_block_map_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       regen;
    logic       block_we;
    logic [9:0] block_w_addr;
    logic [9:0] x_a;
    logic [9:0] y_a;
    logic [9:0] col_addr;
    logic       block_on;
    logic       col_hit;
    logic       init_done;
    logic       block_cleared;
    logic [9:0] cleared_count;

    int        n_checks = 0;
    int        n_errors = 0;
    bit        m_map [0:890];
    bit        map1  [0:890];
    bit [15:0] m_lfsr;
    int        exp_col_q[$];
    int        exp_on_q[$];

    always #5 clk = ~clk;

    block_map_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .regen        (regen),
        .block_w_addr (block_w_addr),
        .block_we     (block_we),
        .x_a          (x_a),
        .y_a          (y_a),
        .col_addr     (col_addr),
        .block_on     (block_on),
        .col_hit      (col_hit),
        .init_done    (init_done),
        .block_cleared(block_cleared),
        .cleared_count(cleared_count)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference generation: col/row derived by division, independent of any counters.
    task automatic gen_model;
        bit fb;
        for (int a = 0; a < 891; a++) begin
            m_map[a] = (m_lfsr[1:0] != 2'b00) && !(((a % 33) % 2 == 1) && ((a / 33) % 2 == 1)) &&
                       (a != 0) && (a != 1) && (a != 33);
            fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
            m_lfsr = {fb, m_lfsr[15:1]};
        end
    endtask

    function automatic int exp_col(input int a);
        return (a >= 0 && a <= 890) ? int'(m_map[a]) : 0;
    endfunction

    function automatic int exp_on(input int x, input int y);
        int bx = x / 16;
        int by = y / 16;
        if (bx <= 32 && by <= 26) return int'(m_map[bx + 33 * by]);
        return 0;
    endfunction

    function automatic int find_one(input int start);
        for (int i = start; i < 891; i++) if (m_map[i]) return i;
        return 0;
    endfunction

    task automatic probe(input int ca, input int x, input int y);
        col_addr = 10'(ca);
        x_a      = 10'(x);
        y_a      = 10'(y);
        exp_col_q.push_back(exp_col(ca));
        exp_on_q.push_back(exp_on(x, y));
        step;
        chk($sformatf("col_hit[%0d]", ca), col_hit, exp_col_q.pop_front());
        chk($sformatf("block_on[%0d,%0d]", x, y), block_on, exp_on_q.pop_front());
    endtask

    task automatic read_map(output int diff);
        diff = 0;
        for (int a = 0; a < 891; a++) begin
            probe(a, 0, 0);
            if (col_hit !== map1[a]) diff++;
        end
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        int bad = 0;
        col_addr = 10'd2;
        x_a = 10'd32;
        y_a = 10'd0;
        while (init_done !== 1'b1 && n < 2000) begin
            step;
            n++;
            if (init_done !== 1'b1 && (col_hit || block_on || block_cleared || cleared_count != 0))
                bad++;
        end
        chk({tag, "_len"}, n, 891);
        chk({tag, "_quiet"}, bad, 0);
    endtask

    task automatic clear_one(input int a, inout int exp_cnt);
        int was;
        was = int'(m_map[a]);
        block_we = 1'b1;
        block_w_addr = 10'(a);
        probe(a, 0, 0);
        m_map[a] = 1'b0;
        exp_cnt += was;
        chk($sformatf("pulse[%0d]", a), block_cleared, was);
        chk($sformatf("count_after[%0d]", a), cleared_count, exp_cnt);
        block_we = 1'b0;
    endtask

    initial begin
        int a, b, c, e, pulses, diff, exp_cnt;
        reset = 1'b1;
        regen = 1'b0;
        block_we = 1'b0;
        block_w_addr = '0;
        x_a = '0;
        y_a = '0;
        col_addr = '0;
        step;
        step;
        chk("rst_init_done", init_done, 0);
        chk("rst_col_hit", col_hit, 0);
        chk("rst_block_on", block_on, 0);
        chk("rst_cleared", block_cleared, 0);
        chk("rst_count", cleared_count, 0);
        reset = 1'b0;
        wait_init("init1");

        m_lfsr = 16'hACE1;
        gen_model;
        map1 = m_map;
        probe(0, 0, 0);  chk("spawn0", col_hit, 0);
        probe(1, 0, 0);  chk("spawn1", col_hit, 0);
        probe(33, 0, 0); chk("spawn33", col_hit, 0);
        probe(34, 0, 0); chk("pillar34", col_hit, 0);
        read_map(diff);

        // Held clear: exactly one pulse, read-before-write on the clearing cycle.
        exp_cnt = 0;
        a = find_one(2);
        block_we = 1'b1;
        block_w_addr = 10'(a);
        probe(a, 0, 0);
        m_map[a] = 1'b0;
        chk("pulse_first", block_cleared, 1);
        chk("count_1", cleared_count, 1);
        exp_cnt = 1;
        pulses = 0;
        repeat (4) begin
            probe(a, 0, 0);
            pulses += int'(block_cleared);
        end
        chk("pulse_hold", pulses, 0);
        block_we = 1'b0;
        probe(a, 0, 0);
        chk("count_hold", cleared_count, 1);

        block_we = 1'b1;
        block_w_addr = 10'd900;
        probe(a, 0, 0);
        chk("oor900_pulse", block_cleared, 0);
        block_w_addr = 10'd891;
        probe(a, 0, 0);
        chk("oor891_pulse", block_cleared, 0);
        block_w_addr = 10'd0;
        probe(0, 0, 0);
        chk("zero_tile_pulse", block_cleared, 0);
        block_we = 1'b0;
        chk("oor_count", cleared_count, 1);

        b = find_one(a + 1);
        clear_one(b, exp_cnt);
        c = find_one(b + 1);
        clear_one(c, exp_cnt);
        chk("count_3", cleared_count, 3);
        clear_one(890, exp_cnt);
        probe(c, 0, 0);
        chk("pulse_idle", block_cleared, 0);
        read_map(diff);

        // Render sweep on a grid that includes both pixel-range edges.
        for (int yy = 0; yy <= 48; yy++) begin
            for (int xx = 0; xx <= 48; xx++) begin
                int x = xx * 11;
                int y = yy * 9;
                int ca = (x / 16 <= 32 && y / 16 <= 26) ? (x / 16 + 33 * (y / 16)) : 1023;
                probe(ca, x, y);
            end
        end
        probe(890, 527, 431);
        probe(1023, 528, 0);
        chk("x528_off", block_on, 0);

        // Regen and clear together: regen wins, then a fresh map from the running LFSR.
        block_we = 1'b1;
        block_w_addr = 10'(find_one(0));
        regen = 1'b1;
        step;
        regen = 1'b0;
        chk("regen_done", init_done, 0);
        chk("regen_pulse", block_cleared, 0);
        chk("regen_count", cleared_count, 0);
        block_w_addr = 10'd100;
        wait_init("init2");
        block_we = 1'b0;
        gen_model;
        read_map(diff);
        chk("regen_differs", (diff > 0) ? 1 : 0, 1);

        e = find_one(2);
        exp_cnt = 0;
        clear_one(e, exp_cnt);
        chk("pre_reset_count", cleared_count, 1);
        reset = 1'b1;
        #1;
        chk("areset_done", init_done, 0);
        chk("areset_count", cleared_count, 0);
        chk("areset_col_hit", col_hit, 0);
        step;
        reset = 1'b0;
        repeat (300) step;
        reset = 1'b1;
        #1;
        chk("mid_init_reset_done", init_done, 0);
        step;
        reset = 1'b0;
        wait_init("init3");
        m_lfsr = 16'hACE1;
        gen_model;
        read_map(diff);
        chk("reset_same_map", diff, 0);

        regen = 1'b1;
        step;
        regen = 1'b0;
        repeat (200) step;
        regen = 1'b1;
        step;
        regen = 1'b0;
        wait_init("init4");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/block_map_ctrl.md
BLOCK_MAP_CTRL -- requirements
Module: block_map_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 33, arena width in 16x16 tiles.
REQ-002 SHALL have parameter ROWS, default 27, arena height in tiles.
REQ-003 SHALL have parameter SEED, default 16'hACE1, LFSR reset value.
REQ-004 SHALL have port clk  input  1  system clock, single clock domain.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port regen  input  1  one-cycle request to regenerate the map.
REQ-007 SHALL have port block_w_addr  input  10  tile address to clear (col + row*COLS).
REQ-008 SHALL have port block_we  input  1  clear enable, may stay high for many cycles.
REQ-009 SHALL have port x_a, y_a  input  10 each  render pixel in arena coordinates.
REQ-010 SHALL have port col_addr  input  10  collision-query tile address.
REQ-011 SHALL have port block_on  output  1  render pixel lies on a soft block.
REQ-012 SHALL have port col_hit  output  1  queried tile holds a soft block.
REQ-013 SHALL have port init_done  output  1  map generated and live.
REQ-014 SHALL have port block_cleared  output  1  one-cycle pulse per block destroyed.
REQ-015 SHALL have port cleared_count  output  10  blocks destroyed since last generation.

Function
REQ-016 SHALL store one bit per tile, COLS*ROWS = 891 entries, addresses 0..890.
REQ-017 SHALL implement FSM states INIT and RUN; reset and regen enter INIT with tile counter 0, col 0, row 0.
REQ-018 In INIT, SHALL write exactly one tile per cycle in address order, tracking col 0..32 and row 0..26 by counters (no division).
REQ-019 Tile written in INIT SHALL be 1 iff LFSR[1:0] != 2'b00, except forced 0 for pillar tiles (col odd AND row odd) and spawn tiles 0, 1, 33.
REQ-020 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, loaded with SEED on reset only (not on regen), stepping once per INIT cycle.
REQ-021 INIT SHALL last exactly 891 cycles; after writing address 890, FSM SHALL enter RUN and init_done SHALL be 1 from the next cycle.
REQ-022 init_done SHALL be 0 throughout INIT.
REQ-023 block_we and block_w_addr SHALL be ignored in INIT.
REQ-024 In RUN, on block_we=1 with block_w_addr <= 890, tile SHALL be written 0 at that clock edge.
REQ-025 block_cleared SHALL pulse 1 for one cycle, registered, the cycle after a RUN write whose tile was 1 beforehand; a write to an already-0 tile SHALL NOT pulse.
REQ-026 cleared_count SHALL increment with each block_cleared pulse and clear to 0 on entry to INIT.
REQ-027 block_w_addr >= 891 SHALL be ignored with no pulse.
REQ-028 block_on SHALL be registered, one-cycle latency: 1 iff x_a[9:4] <= 32, y_a[9:4] <= 26, init_done=1, and tile (x_a[9:4] + 33*y_a[9:4]) = 1.
REQ-029 col_hit SHALL be registered, one-cycle latency: 1 iff col_addr <= 890, init_done=1, and tile = 1.
REQ-030 Read of a tile cleared in the same cycle SHALL return the pre-write value (read-before-write).
REQ-031 regen arriving in INIT SHALL restart INIT from address 0; regen and block_we in the same RUN cycle: regen wins, no clear and no pulse.

Reset
REQ-032 On reset, SHALL set state INIT, counters 0, LFSR SEED, block_on 0, col_hit 0, init_done 0, block_cleared 0, cleared_count 0.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL abort immediately; INIT restarts at address 0 after deassertion, producing an identical map.

Verification
REQ-034 Reset release -> init_done 0 for 891 cycles, then 1; col_hit 0 for col_addr 0, 1, 33, 34 (spawn/pillar).
REQ-035 Pick tile with col_hit=1, hold block_we=1 on it 5 cycles -> exactly one block_cleared pulse, cleared_count 0->1, col_hit 0 afterwards.
REQ-036 block_we=1, block_w_addr=900 in RUN -> no pulse, cleared_count unchanged, map unchanged.
REQ-037 Two resets separated by a run with clears -> identical map after each INIT (compare all 891 col_hit reads).
REQ-038 regen pulse in RUN after 3 clears -> init_done 0 next cycle for 891 cycles, cleared_count 0, new map differs from first.
REQ-039 Sweep x_a=0..527, y_a=0..431 in RUN -> block_on matches col_hit of same tile one cycle later; x_a=528 -> block_on 0.
